// File: rtl/pes_updown_sweep_ctrl_if.sv
// Handshake and status bundle for the up/down sweep controller.
// The master drives requests and configuration. The slave (the controller) drives the counter and status.
interface pes_updown_sweep_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] lo_lim;
    logic [WIDTH-1:0] hi_lim;
    logic [3:0]       num_sweeps;
    logic [WIDTH-1:0] Count;
    logic             UpOrDown;
    logic             busy;
    logic             done;
    logic             err;
    logic [3:0]       sweep_cnt;

    modport master (
        output start, abort, lo_lim, hi_lim, num_sweeps,
        input  Count, UpOrDown, busy, done, err, sweep_cnt
    );

    modport slave (
        input  start, abort, lo_lim, hi_lim, num_sweeps,
        output Count, UpOrDown, busy, done, err, sweep_cnt
    );
endinterface

// File: rtl/pes_updown_sweep_ctrl.sv
// Sweep controller for a WIDTH-bit up/down counter.
// It runs lo -> hi -> lo for a programmed number of sweeps, then pulses done.
module pes_updown_sweep_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic                          Clk,
    input  logic                          reset,
    pes_updown_sweep_ctrl_if.slave        bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_DOWN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             up_q, up_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [3:0]       sweep_cnt_q, sweep_cnt_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [3:0]       n_q, n_d;

    logic             cfg_ok;
    logic [3:0]       sweep_inc;

    // Reject an empty or inverted range up front. This keeps the counter from wrapping mid-sweep.
    assign cfg_ok    = (bus.lo_lim < bus.hi_lim) && (bus.num_sweeps != 4'd0);
    assign sweep_inc = sweep_cnt_q + 4'd1;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        sweep_cnt_d = sweep_cnt_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        n_d         = n_q;
        err_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (cfg_ok) begin
                        lo_d        = bus.lo_lim;
                        hi_d        = bus.hi_lim;
                        n_d         = bus.num_sweeps;
                        count_d     = bus.lo_lim;
                        sweep_cnt_d = 4'd0;
                        state_d     = S_UP;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            S_UP: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (count_q == hi_q) begin
                    count_d = count_q - 1'b1;
                    state_d = S_DOWN;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end

            S_DOWN: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (count_q != lo_q) begin
                    count_d = count_q - 1'b1;
                end else begin
                    sweep_cnt_d = sweep_inc;
                    if (sweep_inc == n_q) begin
                        state_d = S_DONE;
                    end else begin
                        // lo was already shown as the last value of this sweep, so restart one above it.
                        count_d = lo_q + 1'b1;
                        state_d = S_UP;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_UP) || (state_d == S_DOWN);
        up_d   = (state_d == S_UP);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            up_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            sweep_cnt_q <= 4'd0;
            lo_q        <= '0;
            hi_q        <= '0;
            n_q         <= 4'd0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            up_q        <= up_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            sweep_cnt_q <= sweep_cnt_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            n_q         <= n_d;
        end
    end

    assign bus.Count     = count_q;
    assign bus.UpOrDown  = up_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.sweep_cnt = sweep_cnt_q;

endmodule
